riscv_lsu_ctrl: RTL and testbench

Load/store sequencer between the RISC-V core and data memory. It takes the memory request the decoder produces (request, write enable, size code) together with the ALU address and rs2 data. It runs a registered request/ready handshake with the memory, stalls the core until completion, and returns lane-aligned, sign- or zero-extended load data. Misaligned accesses, illegal sizes and memory timeouts are reported as a one-cycle error, with the core released.

---
 rtl/riscv_lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_riscv_lsu_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer: IDLE -> BUSY -> DONE, min 3 cycles per access, +1 per mem_ready_i=0 cycle.
// Core is held via core_stall_req_o until DONE; misalign/illegal size/timeout give a one-cycle error.
module riscv_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        lsu_error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW:0]    cnt_inc;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [3:0]     mem_be_q, mem_be_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wd_q, mem_wd_d;
    logic [31:0]    core_rd_q, core_rd_d;
    logic           err_q, err_d;
    logic [1:0]     off_q, off_d;
    logic [2:0]     size_q, size_d;

    logic           acc_legal;
    logic [3:0]     req_be;
    logic [31:0]    req_wd;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;
    logic [31:0]    ld_data;

    // Request decode: legality, lane enables and replicated store data.
    always_comb begin
        acc_legal = 1'b1;
        req_be    = 4'b0000;
        req_wd    = core_wd_i;
        case (core_size_i)
            3'd0, 3'd4: begin
                req_be = 4'b0001 << core_addr_i[1:0];
                req_wd = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                req_be    = 4'b0011 << {core_addr_i[1], 1'b0};
                req_wd    = {2{core_wd_i[15:0]}};
                acc_legal = ~core_addr_i[0];
            end
            3'd2: begin
                req_be    = 4'b1111;
                acc_legal = (core_addr_i[1:0] == 2'b00);
            end
            default: acc_legal = 1'b0;
        endcase
        if (core_we_i && core_size_i[2]) begin
            acc_legal = 1'b0;
        end
    end

    always_comb begin
        lane_b  = mem_rd_i[{off_q, 3'b000} +: 8];
        lane_h  = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        ld_data = mem_rd_i;
        case (size_q)
            3'd0:    ld_data = {{24{lane_b[7]}}, lane_b};
            3'd4:    ld_data = {24'b0, lane_b};
            3'd1:    ld_data = {{16{lane_h[15]}}, lane_h};
            3'd5:    ld_data = {16'b0, lane_h};
            default: ld_data = mem_rd_i;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        core_rd_d  = core_rd_q;
        err_d      = 1'b0;
        off_d      = off_q;
        size_d     = size_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (acc_legal) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = core_we_i;
                        mem_be_d   = req_be;
                        mem_addr_d = {core_addr_i[31:2], 2'b00};
                        mem_wd_d   = req_wd;
                        off_d      = core_addr_i[1:0];
                        size_d     = core_size_i;
                        cnt_d      = '0;
                        state_d    = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (mem_ready_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        core_rd_d = ld_data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                    if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL)) begin
                        mem_req_d = 1'b0;
                        core_rd_d = '0;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            core_rd_q  <= '0;
            err_q      <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            core_rd_q  <= core_rd_d;
            err_q      <= err_d;
            off_q      <= off_d;
            size_q     <= size_d;
        end
    end

    assign core_stall_req_o = !rst_i && (((state_q == IDLE) && core_req_i) || (state_q == BUSY));
    assign core_rd_o        = core_rd_q;
    assign lsu_error_o      = err_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_be_o         = mem_be_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wd_o         = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Bench for riscv_lsu_ctrl: transaction-level model predicts every cycle's outputs;
// directed test-plan vectors pin literal values, then randomized accesses follow.
module tb_riscv_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wd_i = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_req_o;
    logic        lsu_error_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = '0;
    logic        mem_ready_i = 1'b0;

    always #5 clk = ~clk;

    riscv_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_stall_req_o(core_stall_req_o),
        .lsu_error_o     (lsu_error_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd_i),
        .mem_ready_i     (mem_ready_i)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle, set by the stimulus before the negedge.
    logic        exp_stall, exp_req, exp_err, exp_we, exp_chk_mem;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wd, exp_rd, rd_model;

    int          stall_cnt, req_cnt, err_cnt;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd, seen_addr;
    logic        seen_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        check("stall", 32'(core_stall_req_o), 32'(exp_stall));
        check("mem_req", 32'(mem_req_o), 32'(exp_req));
        check("lsu_error", 32'(lsu_error_o), 32'(exp_err));
        check("core_rd", core_rd_o, exp_rd);
        if (exp_chk_mem) begin
            check("mem_we", 32'(mem_we_o), 32'(exp_we));
            check("mem_be", 32'(mem_be_o), 32'(exp_be));
            check("mem_addr", mem_addr_o, exp_addr);
            check("mem_wd", mem_wd_o, exp_wd);
        end
        if (core_stall_req_o) stall_cnt++;
        if (lsu_error_o) err_cnt++;
        if (mem_req_o) begin
            req_cnt++;
            seen_be   = mem_be_o;
            seen_wd   = mem_wd_o;
            seen_addr = mem_addr_o;
            seen_we   = mem_we_o;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] sz, input logic [31:0] addr);
        int n = nbytes(sz);
        if (n == 0) return 1'b0;
        if (we && n < 4 && sz >= 3'd4) return 1'b0;
        return (int'(addr[1:0]) % n) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] addr);
        int n = nbytes(sz);
        logic [3:0] m = 4'((1 << n) - 1);
        return m << addr[1:0];
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] sz, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int n = nbytes(sz);
        logic [31:0] v = rd >> (8 * int'(addr[1:0]));
        logic [31:0] keep;
        if (n < 4) begin
            keep = (32'h1 << (8 * n)) - 32'h1;
            v    = v & keep;
            if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1]) v = v | ~keep;
        end
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_err   = 1'b0;
        exp_rd    = rd_model;
    endtask

    task automatic idle();
        core_req_i  = 1'b0;
        core_we_i   = 1'($urandom_range(1));
        core_addr_i = $urandom;
        mem_ready_i = 1'($urandom_range(1));
        mem_rd_i    = $urandom;
        set_idle_exp();
        tick();
    endtask

    task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int waits);
        logic ok;
        logic tmo;
        ok  = legal(we, sz, addr);
        tmo = 1'b0;
        stall_cnt = 0;
        req_cnt   = 0;
        err_cnt   = 0;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'($urandom_range(1));
        mem_rd_i    = $urandom;
        exp_stall   = 1'b1;
        exp_req     = 1'b0;
        exp_err     = 1'b0;
        exp_chk_mem = 1'b0;
        exp_rd      = rd_model;
        tick();
        if (ok) begin
            exp_req     = 1'b1;
            exp_chk_mem = 1'b1;
            exp_we      = we;
            exp_be      = model_be(sz, addr);
            exp_addr    = {addr[31:2], 2'b00};
            exp_wd      = model_wd(sz, wd);
            for (int j = 1; j <= waits + 1; j++) begin
                mem_ready_i = (j == waits + 1);
                mem_rd_i    = mem_ready_i ? rdata : $urandom;
                tick();
                if (!mem_ready_i && j == TO) begin
                    tmo = 1'b1;
                    break;
                end
            end
        end
        if (ok && tmo) rd_model = '0;
        else if (ok && !we) rd_model = model_ld(sz, addr, rdata);
        exp_stall   = 1'b0;
        exp_req     = 1'b0;
        exp_chk_mem = 1'b0;
        exp_err     = !ok || tmo;
        exp_rd      = rd_model;
        mem_ready_i = 1'($urandom_range(1));
        mem_rd_i    = $urandom;
        tick();
        core_req_i = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr;

        // Reset with a pending request: outputs must all read zero and stall stays low.
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_size_i = 3'd2;
        mem_ready_i = 1'b1;
        mem_rd_i    = $urandom;
        @(posedge clk);
        #1;
        rd_model    = '0;
        set_idle_exp();
        exp_chk_mem = 1'b1;
        exp_we      = 1'b0;
        exp_be      = '0;
        exp_addr    = '0;
        exp_wd      = '0;
        tick();
        tick();
        rst_i = 1'b0;
        idle();
        exp_chk_mem = 1'b0;

        run_op(1'b0, 3'd2, 32'h100, $urandom, 32'hDEADBEEF, 0);
        check("lw_rd", core_rd_o, 32'hDEADBEEF);
        check("lw_be", 32'(seen_be), 32'hF);
        check("lw_addr", seen_addr, 32'h100);
        check("lw_stall", 32'(stall_cnt), 32'd2);

        run_op(1'b0, 3'd0, 32'h103, $urandom, 32'h80FF_0000, 0);
        check("lb_rd", core_rd_o, 32'hFFFFFF80);
        check("lb_be", 32'(seen_be), 32'h8);
        run_op(1'b0, 3'd4, 32'h103, $urandom, 32'h80FF_0000, 1);
        check("lbu_rd", core_rd_o, 32'h00000080);

        run_op(1'b1, 3'd1, 32'h22, 32'h1234ABCD, $urandom, 3);
        check("sh_be", 32'(seen_be), 32'hC);
        check("sh_wd", seen_wd, 32'hABCDABCD);
        check("sh_we", 32'(seen_we), 32'd1);
        check("sh_stall", 32'(stall_cnt), 32'd5);
        check("sh_rd", core_rd_o, 32'h00000080);
        check("sh_err", 32'(err_cnt), 32'd0);
        idle();

        run_op(1'b0, 3'd2, 32'h101, $urandom, $urandom, 0);
        check("lw_mis_req", 32'(req_cnt), 32'd0);
        check("lw_mis_err", 32'(err_cnt), 32'd1);
        check("lw_mis_stall", 32'(stall_cnt), 32'd1);
        run_op(1'b1, 3'd4, 32'h40, $urandom, $urandom, 0);
        check("sb4_req", 32'(req_cnt), 32'd0);
        check("sb4_err", 32'(err_cnt), 32'd1);
        idle();

        run_op(1'b0, 3'd2, 32'h200, $urandom, $urandom, 20);
        check("to_req", 32'(req_cnt), 32'd4);
        check("to_err", 32'(err_cnt), 32'd1);
        check("to_rd", core_rd_o, 32'h0);
        check("to_stall", 32'(stall_cnt), 32'd5);

        // Reset in the middle of a load that never completes.
        run_op(1'b0, 3'd2, 32'h44, $urandom, 32'h5A5A_1234, 0);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        exp_stall   = 1'b1;
        exp_rd      = rd_model;
        tick();
        exp_req     = 1'b1;
        exp_chk_mem = 1'b1;
        exp_we      = 1'b0;
        exp_be      = 4'hF;
        exp_addr    = 32'h300;
        exp_wd      = core_wd_i;
        tick();
        tick();
        rst_i     = 1'b1;
        exp_stall = 1'b0;
        tick();
        rd_model = '0;
        exp_req  = 1'b0;
        exp_be   = '0;
        exp_addr = '0;
        exp_wd   = '0;
        exp_rd   = '0;
        tick();
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        mem_rd_i    = $urandom;
        tick();
        tick();
        exp_chk_mem = 1'b0;

        for (int k = 0; k < 200; k++) begin
            we   = 1'($urandom_range(1));
            sz   = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd2 - 3'($urandom_range(2));
            if (!we && $urandom_range(1) == 1 && sz != 3'd2) sz = sz | 3'd4;
            addr = $urandom;
            if ($urandom_range(3) != 0) begin
                if (nbytes(sz) == 2) addr[0] = 1'b0;
                if (nbytes(sz) == 4) addr[1:0] = 2'b00;
            end
            run_op(we, sz, addr, $urandom, $urandom, $urandom_range(5));
            repeat ($urandom_range(2)) idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
